// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types and BRAM word packing for the perceptron datapath
package perceptron_pkg;

    localparam int PCP_ADDR_W = 9;
    localparam int PCP_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_W      = 3'd1,
        ST_GET_X      = 3'd2,
        ST_WRITE_LAST = 3'd3,
        ST_LAUNCH     = 3'd4
    } state_t;

    // Weight in the upper half, input in the lower half; the controller unpacks the same way.
    function automatic logic [2*PCP_DATA_W-1:0] pack_pair(
        input logic [PCP_DATA_W-1:0] w,
        input logic [PCP_DATA_W-1:0] x
    );
        return {w, x};
    endfunction

endpackage

// File: rtl/perceptron_bram_loader.sv
// rtl/perceptron_bram_loader.sv - packs a weight/input word stream into BRAM and launches the controller
module perceptron_bram_loader
    import perceptron_pkg::*;
#(
    parameter int ADDR_W = PCP_ADDR_W,
    parameter int DATA_W = PCP_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    input  logic                ctrl_busy,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [2*DATA_W-1:0] bram_din,
    output logic [ADDR_W-1:0]   start_addr,
    output logic [ADDR_W-1:0]   end_addr,
    output logic                launch,
    output logic                overflow,
    output logic                odd_frame
);

    // The top address is reserved so an exclusive end_addr always fits in ADDR_W bits.
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   frame_base_q;
    logic [DATA_W-1:0]   weight_q;

    logic                ready_c;
    logic                first_word;
    logic                hold_w;
    logic                pair_en;
    logic [DATA_W-1:0]   pair_x;
    logic                set_odd;

    always_comb begin
        state_n    = state_q;
        ready_c    = 1'b0;
        first_word = 1'b0;
        hold_w     = 1'b0;
        pair_en    = 1'b0;
        pair_x     = '0;
        set_odd    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = !ctrl_busy;
                if (s_valid && !ctrl_busy) begin
                    first_word = 1'b1;
                    hold_w     = 1'b1;
                    if (s_last) begin
                        set_odd = 1'b1;
                        state_n = ST_WRITE_LAST;
                    end else begin
                        state_n = ST_GET_X;
                    end
                end
            end
            ST_GET_W: begin
                ready_c = 1'b1;
                if (s_valid) begin
                    hold_w = 1'b1;
                    if (s_last) begin
                        set_odd = 1'b1;
                        state_n = ST_WRITE_LAST;
                    end else begin
                        state_n = ST_GET_X;
                    end
                end
            end
            ST_GET_X: begin
                ready_c = 1'b1;
                if (s_valid) begin
                    pair_en = 1'b1;
                    pair_x  = s_data;
                    state_n = s_last ? ST_LAUNCH : ST_GET_W;
                end
            end
            ST_WRITE_LAST: begin
                pair_en = 1'b1;
                state_n = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Gated by reset so every output reads 0 while rst_n is low.
    assign s_ready = rst_n & ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            frame_base_q <= '0;
            weight_q     <= '0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_din     <= '0;
            start_addr   <= '0;
            end_addr     <= '0;
            launch       <= 1'b0;
            overflow     <= 1'b0;
            odd_frame    <= 1'b0;
        end else begin
            bram_we <= 1'b0;
            launch  <= 1'b0;
            if (first_word) begin
                wr_ptr_q     <= base_addr;
                frame_base_q <= base_addr;
                overflow     <= 1'b0;
                odd_frame    <= 1'b0;
            end
            if (hold_w) begin
                weight_q <= s_data;
            end
            if (set_odd) begin
                odd_frame <= 1'b1;
            end
            if (pair_en) begin
                if (wr_ptr_q == ADDR_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    bram_we   <= 1'b1;
                    bram_addr <= wr_ptr_q;
                    bram_din  <= pack_pair(weight_q, pair_x);
                    wr_ptr_q  <= wr_ptr_q + 1'b1;
                end
            end
            // Registered launch: start/end are already updated and stable when it is seen.
            if (state_q == ST_LAUNCH) begin
                launch     <= 1'b1;
                start_addr <= frame_base_q;
                end_addr   <= wr_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_bram_loader.sv
// tb/tb_perceptron_bram_loader.sv - scoreboard bench for perceptron_bram_loader
module tb_perceptron_bram_loader;

    logic        clk;
    logic        rst_n;
    logic [8:0]  base_addr;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        ctrl_busy;
    logic        bram_we;
    logic [8:0]  bram_addr;
    logic [31:0] bram_din;
    logic [8:0]  start_addr;
    logic [8:0]  end_addr;
    logic        launch;
    logic        overflow;
    logic        odd_frame;

    perceptron_bram_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_addr  (base_addr),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .ctrl_busy  (ctrl_busy),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .launch     (launch),
        .overflow   (overflow),
        .odd_frame  (odd_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [8:0] start_a;
        logic [8:0] end_a;
        logic       odd;
        logic       ovf;
    } ln_t;

    int          tests = 0;
    int          fails = 0;
    wr_t         exp_wr[$];
    ln_t         exp_ln[$];
    logic [15:0] frame_q[$];
    int          first_wait;
    int          launch_count = 0;
    logic        launch_prev = 1'b0;
    wr_t         got_wr, want_wr;
    ln_t         got_ln, want_ln;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_we) begin
                tests++;
                got_wr = '{addr: bram_addr, data: bram_din};
                if (exp_wr.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bram_addr, bram_din);
                end else begin
                    want_wr = exp_wr.pop_front();
                    if (got_wr !== want_wr) begin
                        fails++;
                        $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 bram_addr, bram_din, want_wr.addr, want_wr.data);
                    end
                end
            end
            if (launch) begin
                tests++;
                launch_count++;
                got_ln = '{start_a: start_addr, end_a: end_addr, odd: odd_frame, ovf: overflow};
                if (exp_ln.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_launch: got start=%0d end=%0d", start_addr, end_addr);
                end else begin
                    want_ln = exp_ln.pop_front();
                    if (got_ln !== want_ln) begin
                        fails++;
                        $display("FAIL launch: got start=%0d end=%0d odd=%0b ovf=%0b, required start=%0d end=%0d odd=%0b ovf=%0b",
                                 start_addr, end_addr, odd_frame, overflow,
                                 want_ln.start_a, want_ln.end_a, want_ln.odd, want_ln.ovf);
                    end
                end
                if (launch_prev) begin
                    fails++;
                    $display("FAIL launch_width: got launch high two cycles, required one");
                end
            end
            launch_prev = launch;
        end else begin
            launch_prev = 1'b0;
        end
    end

    // Reference model of one complete frame held in frame_q.
    task automatic model_frame(input int base);
        int ptr;
        int n;
        logic ovf;
        logic [15:0] w, x;
        ptr = base;
        ovf = 1'b0;
        n   = frame_q.size();
        for (int i = 0; i < n; i += 2) begin
            w = frame_q[i];
            x = (i + 1 < n) ? frame_q[i+1] : 16'h0000;
            if (ptr == 511) begin
                ovf = 1'b1;
            end else begin
                exp_wr.push_back('{addr: ptr[8:0], data: {w, x}});
                ptr++;
            end
        end
        exp_ln.push_back('{start_a: base[8:0], end_a: ptr[8:0], odd: n[0], ovf: ovf});
    endtask

    task automatic send_frame(input int base, input bit toggle, input int nsend);
        int  n;
        bit  acc;
        base_addr = base[8:0];
        for (int i = 0; i < nsend; i++) begin
            s_data  = frame_q[i];
            s_last  = (i == frame_q.size() - 1);
            s_valid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 100) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (i == 0) first_wait = n;
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: word %0d not accepted in %0d cycles", i, n);
                i = nsend;
            end
            if (toggle) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_launch(input string name);
        int n;
        n = 0;
        while (exp_ln.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        tests++;
        if (exp_ln.size() != 0 || exp_wr.size() != 0) begin
            fails++;
            $display("FAIL %s_done: got %0d launches and %0d writes pending, required 0", name, exp_ln.size(), exp_wr.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({s_ready, bram_we, bram_addr, bram_din, start_addr, end_addr, launch, overflow, odd_frame} !== '0) begin
            fails++;
            $display("FAIL %s: got rdy=%0b we=%0b addr=%0d din=%h start=%0d end=%0d launch=%0b ovf=%0b odd=%0b, required all 0",
                     name, s_ready, bram_we, bram_addr, bram_din, start_addr, end_addr, launch, overflow, odd_frame);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        check_all_zero("reset_init");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame_q = '{16'h000a, 16'h000b, 16'h000c, 16'h000d};
        exp_wr.push_back('{addr: 9'd40, data: 32'h000a_000b});
        send_frame(40, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_frame");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (exp_wr.size() != 0 || launch_count != 0) begin
            fails++;
            $display("FAIL reset_after: got %0d writes pending, %0d launches, required 0 and 0", exp_wr.size(), launch_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int lc;
        lc = launch_count;
        frame_q = {};
        for (int i = 0; i < 16; i++) frame_q.push_back(16'h0002);
        model_frame(0);
        send_frame(0, 1'b0, 16);
        wait_launch("basic");
        tests++;
        if (launch_count != lc + 1) begin
            fails++;
            $display("FAIL basic_launch_count: got %0d, required %0d", launch_count - lc, 1);
        end
    endtask

    task automatic test_backpressure;
        frame_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        model_frame(100);
        send_frame(100, 1'b1, 6);
        wait_launch("backpressure");
    endtask

    task automatic test_odd;
        frame_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        model_frame(10);
        send_frame(10, 1'b0, 5);
        wait_launch("odd");
        tests++;
        if (odd_frame !== 1'b1) begin
            fails++;
            $display("FAIL odd_sticky: got %0b, required 1", odd_frame);
        end
    endtask

    task automatic test_overflow;
        frame_q = '{16'h00a1, 16'h00b1, 16'h00a2, 16'h00b2, 16'h00a3, 16'h00b3, 16'h00a4, 16'h00b4};
        model_frame(509);
        send_frame(509, 1'b0, 8);
        wait_launch("overflow");
        tests++;
        if (overflow !== 1'b1 || odd_frame !== 1'b0) begin
            fails++;
            $display("FAIL overflow_sticky: got ovf=%0b odd=%0b, required ovf=1 odd=0", overflow, odd_frame);
        end
    endtask

    task automatic test_busy;
        int bad;
        frame_q = '{16'h0f01, 16'h0f02, 16'h0f03, 16'h0f04};
        model_frame(20);
        ctrl_busy = 1'b1;
        base_addr = 9'd20;
        s_data    = frame_q[0];
        s_last    = 1'b0;
        s_valid   = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (s_ready !== 1'b0) begin
                fails++;
                bad++;
                $display("FAIL busy_ready: cycle %0d got s_ready=%0b, required 0", i, s_ready);
            end
        end
        @(posedge clk);
        #1;
        ctrl_busy = 1'b0;
        send_frame(20, 1'b0, 4);
        tests++;
        if (first_wait != 1) begin
            fails++;
            $display("FAIL busy_release: got first accept after %0d cycles, required 1", first_wait);
        end
        wait_launch("busy");
        tests++;
        if (overflow !== 1'b0 || odd_frame !== 1'b0) begin
            fails++;
            $display("FAIL busy_clear: got ovf=%0b odd=%0b, required 0 and 0", overflow, odd_frame);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        base_addr = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        ctrl_busy = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_odd();
        test_overflow();
        test_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
